// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU result path, the result buffer and the
// downstream consumer.
//   in_data / in_valid   : ALU result word and its qualifier (no backpressure)
//   out_data / out_valid : head-of-FIFO word and its qualifier
//   out_ready            : consumer accepts the head this cycle
// Modport master is the buffer side; modport slave is the ALU/consumer side.
interface alu_result_buffer_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

  modport slave (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Result buffer behind the ALU. Every word presented with in_valid is written
// into a small FIFO and offered to the consumer show-ahead over a valid/ready
// handshake. Because the ALU cannot be stalled, a word arriving while the FIFO
// is full and nothing is leaving is dropped and the sticky overflow bit is set.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (pointers, count, overflow)
//   bus      : in_data/in_valid from the ALU, out_data/out_valid/out_ready
//              to the consumer
//   count    : occupied entries
//   full     : count == DEPTH
//   empty    : count == 0
//   overflow : sticky, a result was dropped since the last reset
module alu_result_buffer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  alu_result_buffer_if.master          bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             pop;
  logic             push;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a word when the consumer is draining.
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = bus.in_valid && (!full || pop);

  // Control state: pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.in_valid && !push) overflow_q <= 1'b1;
    end
  end

  // Storage is data only and is never cleared; empty masks it on the output.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
  localparam int WIDTH = 6;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  alu_result_buffer_if #(.WIDTH(WIDTH)) bus ();

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Queue model of the buffer and the sticky flag.
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf = 1'b0;
  bit               m_full;
  bit               m_pop;
  // Words seen leaving the DUT, in order.
  logic [WIDTH-1:0] pl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      m_pop  = (m_q.size() > 0) && bus.out_ready;
      if (m_pop) void'(m_q.pop_front());
      if (bus.in_valid) begin
        if (!m_full || m_pop) m_q.push_back(bus.in_data);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", int'(bus.out_valid), int'(m_q.size() > 0));
      chk("cyc_data", int'(bus.out_data), (m_q.size() > 0) ? int'(m_q[0]) : 0);
      chk("cyc_count", int'(count), m_q.size());
      chk("cyc_full", int'(full), int'(m_q.size() == DEPTH));
      chk("cyc_empty", int'(empty), int'(m_q.size() == 0));
      chk("cyc_ovf", int'(overflow), int'(m_ovf));
      if (!rst && bus.out_valid && bus.out_ready) pl.push_back(bus.out_data);
    end
  end

  task automatic step(input bit iv, input logic [WIDTH-1:0] d, input bit rdy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic fill4();
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0);
  endtask

  initial begin
    int exp_seq[5];
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step(1'b0, '0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Single pass-through
    step(1'b1, 6'h05, 1'b1);
    chk("pt_valid", int'(bus.out_valid), 1);
    chk("pt_data", int'(bus.out_data), 'h05);
    step(1'b0, '0, 1'b1);
    chk("pt_empty", int'(empty), 1);

    // Fill and stall
    fill4();
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 4);
    chk("fill_head", int'(bus.out_data), 'h01);
    chk("model_size", m_q.size(), 4);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("hold_head", int'(bus.out_data), 'h01);

    // Overflow
    step(1'b1, 6'h3F, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 4);
    pl.delete();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("drain_len", pl.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("drain_word", (i < pl.size()) ? int'(pl[i]) : -1, i + 1);
    chk("drain_empty", int'(empty), 1);
    chk("ovf_sticky", int'(overflow), 1);
    step(1'b0, '0, 1'b1);
    chk("ovf_still", int'(overflow), 1);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk("ovf_clear", int'(overflow), 0);

    // Full with simultaneous pop and push
    fill4();
    pl.delete();
    step(1'b1, 6'h2A, 1'b1);
    chk("pp_count", int'(count), 4);
    chk("pp_ovf", int'(overflow), 0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    exp_seq = '{'h01, 'h02, 'h03, 'h04, 'h2A};
    chk("pp_len", pl.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("pp_word", (i < pl.size()) ? int'(pl[i]) : -1, exp_seq[i]);

    // Stream across pointer wrap with out_ready toggling
    pl.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, WIDTH'(i), 1'b1);
      step(1'b0, '0, 1'b0);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("wrap_len", pl.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("wrap_word", (i < pl.size()) ? int'(pl[i]) : -1, i);
    chk("wrap_empty", int'(empty), 1);

    // Mid-operation reset with three entries held
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(6'h20 + i), 1'b0);
    chk("mid_count", int'(count), 3);
    rst = 1'b1;
    step(1'b1, 6'h11, 1'b1);
    rst = 1'b0;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_data", int'(bus.out_data), 0);
    step(1'b0, '0, 1'b1);
    chk("post_rst_empty", int'(empty), 1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
